// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and destination scoreboard for the register file.
// Two requesters (ALU, load unit) share one registered write port, with
// round-robin arbitration on contention. A busy mask tracks reserved
// destinations whose write-back has not yet been granted.
module regfile_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_req,
  input  logic [ADDR_W-1:0]    alu_reg,
  input  logic [DATA_W-1:0]    alu_data,
  output logic                 alu_gnt,
  input  logic                 mem_req,
  input  logic [ADDR_W-1:0]    mem_reg,
  input  logic [DATA_W-1:0]    mem_data,
  output logic                 mem_gnt,
  input  logic                 reserve_en,
  input  logic [ADDR_W-1:0]    reserve_reg,
  output logic [2**ADDR_W-1:0] busy,
  output logic                 RegWrite,
  output logic [ADDR_W-1:0]    Write_Reg,
  output logic [DATA_W-1:0]    Write_Bus
);

  localparam int NREG = 2**ADDR_W;

  // Last winner: 0 = ALU, 1 = MEM. Reset to MEM so the ALU wins the first tie.
  logic                r_last;
  logic                r_we;
  logic [ADDR_W-1:0]   r_wreg;
  logic [DATA_W-1:0]   r_wdata;
  logic [NREG-1:0]     r_busy;

  logic                w_alu_gnt;
  logic                w_mem_gnt;
  logic                w_any_gnt;
  logic [ADDR_W-1:0]   w_win_reg;
  logic [DATA_W-1:0]   w_win_data;
  logic [NREG-1:0]     w_busy_nxt;

  // Grants: a lone request wins; on contention the non-last requester wins.
  // Both are gated by reset so nothing is granted while the block is held.
  assign w_alu_gnt  = rst_n & alu_req & (~mem_req | r_last);
  assign w_mem_gnt  = rst_n & mem_req & (~alu_req | ~r_last);
  assign w_any_gnt  = w_alu_gnt | w_mem_gnt;
  assign w_win_reg  = w_mem_gnt ? mem_reg  : alu_reg;
  assign w_win_data = w_mem_gnt ? mem_data : alu_data;

  assign alu_gnt   = w_alu_gnt;
  assign mem_gnt   = w_mem_gnt;
  assign RegWrite  = r_we;
  assign Write_Reg = r_wreg;
  assign Write_Bus = r_wdata;
  assign busy      = r_busy;

  // Scoreboard next state: the granted write clears its bit, then a reservation
  // sets its bit, so a same-edge reservation supersedes the completing write.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_any_gnt)  w_busy_nxt[w_win_reg]   = 1'b0;
    if (reserve_en) w_busy_nxt[reserve_reg] = 1'b1;
  end

  // Round-robin pointer: only moves when someone is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_last <= 1'b1;
    else if (w_any_gnt) r_last <= w_mem_gnt;
  end

  // Registered write port: enable pulses per grant, address/data hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_wreg  <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_any_gnt;
      if (w_any_gnt) begin
        r_wreg  <= w_win_reg;
        r_wdata <= w_win_data;
      end
    end
  end

  // Busy mask register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: a constant vector table, hand sequences for
// arbitration order, same-register ties and asynchronous reset, then random
// traffic checked against a behavioural model.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        alu_req, mem_req, reserve_en;
  logic [3:0]  alu_reg, mem_reg, reserve_reg;
  logic [15:0] alu_data, mem_data;
  logic        alu_gnt, mem_gnt;
  logic [15:0] busy;
  logic        RegWrite;
  logic [3:0]  Write_Reg;
  logic [15:0] Write_Bus;

  regfile_wb_arbiter #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_req(alu_req), .alu_reg(alu_reg), .alu_data(alu_data), .alu_gnt(alu_gnt),
    .mem_req(mem_req), .mem_reg(mem_reg), .mem_data(mem_data), .mem_gnt(mem_gnt),
    .reserve_en(reserve_en), .reserve_reg(reserve_reg), .busy(busy),
    .RegWrite(RegWrite), .Write_Reg(Write_Reg), .Write_Bus(Write_Bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: who went last, which registers are outstanding, and
  // what the write port shows.
  int          m_last;      // 0 = ALU, 1 = MEM
  bit          m_busy[16];
  bit          m_we;
  int          m_wreg;
  int          m_wdata;
  int          m_win;       // -1 none, 0 ALU, 1 MEM (for the current cycle)

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int model_busy_word();
    int w = 0;
    for (int i = 0; i < 16; i++) if (m_busy[i]) w |= (1 << i);
    return w;
  endfunction

  task automatic model_reset();
    m_last = 1; m_we = 0; m_wreg = 0; m_wdata = 0;
    for (int i = 0; i < 16; i++) m_busy[i] = 0;
  endtask

  // Decide the winner from current inputs, then advance the model over the edge.
  task automatic model_step();
    if (alu_req && mem_req) m_win = (m_last == 1) ? 0 : 1;
    else if (alu_req)       m_win = 0;
    else if (mem_req)       m_win = 1;
    else                    m_win = -1;
    if (m_win >= 0) begin
      m_we    = 1;
      m_wreg  = (m_win == 0) ? int'(alu_reg)  : int'(mem_reg);
      m_wdata = (m_win == 0) ? int'(alu_data) : int'(mem_data);
      m_last  = m_win;
      m_busy[m_wreg] = 0;
    end else begin
      m_we = 0;
    end
    if (reserve_en) m_busy[reserve_reg] = 1;
  endtask

  // One cycle: sample grants mid-cycle, advance model, cross the edge, settle.
  task automatic cyc(output bit ag, output bit mg);
    #2;
    ag = alu_gnt;
    mg = mem_gnt;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_req = 0; alu_reg = 0; alu_data = 0;
    mem_req = 0; mem_reg = 0; mem_data = 0;
    reserve_en = 0; reserve_reg = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    #3;
    chk("rst RegWrite", int'(RegWrite), 0);
    chk("rst Write_Reg", int'(Write_Reg), 0);
    chk("rst Write_Bus", int'(Write_Bus), 0);
    chk("rst busy", int'(busy), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit        areq; bit [3:0] areg; bit [15:0] adat;
    bit        mreq; bit [3:0] mreg; bit [15:0] mdat;
    bit        ren;  bit [3:0] rreg;
    bit        e_ag; bit e_mg;
    bit        e_we; bit [3:0] e_wreg; bit [15:0] e_wdat; bit [15:0] e_busy;
  } vec_t;

  vec_t vt[9];

  initial begin
    bit ag, mg;
    bit ap, mp;
    idle_inputs();
    rst_n = 0;
    model_reset();

    //        areq areg adat     mreq mreg mdat     ren rreg  ag mg  we wreg wdat     busy
    vt[0] = '{1, 3, 16'hBEEF, 0, 0, 16'h0000, 0, 0,  1, 0,  1, 3, 16'hBEEF, 16'h0000};
    vt[1] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,  0, 0,  0, 3, 16'hBEEF, 16'h0000};
    vt[2] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 1, 5,  0, 0,  0, 3, 16'hBEEF, 16'h0020};
    vt[3] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,  0, 0,  0, 3, 16'hBEEF, 16'h0020};
    vt[4] = '{0, 0, 16'h0000, 1, 5, 16'h1234, 0, 0,  0, 1,  1, 5, 16'h1234, 16'h0000};
    vt[5] = '{1, 7, 16'h0777, 0, 0, 16'h0000, 1, 7,  1, 0,  1, 7, 16'h0777, 16'h0080};
    vt[6] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,  0, 0,  0, 7, 16'h0777, 16'h0080};
    vt[7] = '{1, 1, 16'h1111, 1, 2, 16'h2222, 0, 0,  0, 1,  1, 2, 16'h2222, 16'h0080};
    vt[8] = '{1, 7, 16'h0007, 0, 0, 16'h0000, 0, 0,  1, 0,  1, 7, 16'h0007, 16'h0000};

    @(posedge clk);
    #1;
    do_reset();

    // Vector table from reset.
    for (int i = 0; i < 9; i++) begin
      alu_req = vt[i].areq; alu_reg = vt[i].areg; alu_data = vt[i].adat;
      mem_req = vt[i].mreq; mem_reg = vt[i].mreg; mem_data = vt[i].mdat;
      reserve_en = vt[i].ren; reserve_reg = vt[i].rreg;
      cyc(ag, mg);
      chk($sformatf("vec%0d alu_gnt", i), int'(ag), int'(vt[i].e_ag));
      chk($sformatf("vec%0d mem_gnt", i), int'(mg), int'(vt[i].e_mg));
      chk($sformatf("vec%0d RegWrite", i), int'(RegWrite), int'(vt[i].e_we));
      chk($sformatf("vec%0d Write_Reg", i), int'(Write_Reg), int'(vt[i].e_wreg));
      chk($sformatf("vec%0d Write_Bus", i), int'(Write_Bus), int'(vt[i].e_wdat));
      chk($sformatf("vec%0d busy", i), int'(busy), int'(vt[i].e_busy));
    end

    // Continuous contention from reset: ALU, MEM, ALU, MEM with no idle cycle.
    do_reset();
    alu_req = 1; alu_reg = 1; alu_data = 16'h1111;
    mem_req = 1; mem_reg = 2; mem_data = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      cyc(ag, mg);
      chk($sformatf("rr%0d alu_gnt", i), int'(ag), (i % 2 == 0) ? 1 : 0);
      chk($sformatf("rr%0d mem_gnt", i), int'(mg), (i % 2 == 0) ? 0 : 1);
      chk($sformatf("rr%0d RegWrite", i), int'(RegWrite), 1);
      chk($sformatf("rr%0d Write_Reg", i), int'(Write_Reg), (i % 2 == 0) ? 1 : 2);
      chk($sformatf("rr%0d Write_Bus", i), int'(Write_Bus), (i % 2 == 0) ? 'h1111 : 'h2222);
    end
    idle_inputs();

    // Same register tie with last=ALU: MEM first, then ALU; final value AAAA.
    alu_req = 1; alu_reg = 0; alu_data = 16'h0000;
    cyc(ag, mg);
    chk("tie prep alu_gnt", int'(ag), 1);
    alu_req = 1; alu_reg = 9; alu_data = 16'hAAAA;
    mem_req = 1; mem_reg = 9; mem_data = 16'h5555;
    cyc(ag, mg);
    chk("tie1 mem_gnt", int'(mg), 1);
    chk("tie1 alu_gnt", int'(ag), 0);
    chk("tie1 Write_Bus", int'(Write_Bus), 'h5555);
    mem_req = 0;
    cyc(ag, mg);
    chk("tie2 alu_gnt", int'(ag), 1);
    chk("tie2 Write_Reg", int'(Write_Reg), 9);
    chk("tie2 Write_Bus", int'(Write_Bus), 'hAAAA);
    idle_inputs();

    // Asynchronous reset with a pending write and busy=00F0.
    do_reset();
    for (int r = 4; r < 8; r++) begin
      reserve_en = 1; reserve_reg = 4'(r);
      if (r == 7) begin alu_req = 1; alu_reg = 8; alu_data = 16'h1234; end
      cyc(ag, mg);
    end
    chk("pre-rst RegWrite", int'(RegWrite), 1);
    chk("pre-rst busy", int'(busy), 'h00F0);
    alu_req = 1; reserve_en = 0;
    #1;
    rst_n = 0;
    #1;
    chk("async RegWrite", int'(RegWrite), 0);
    chk("async Write_Reg", int'(Write_Reg), 0);
    chk("async Write_Bus", int'(Write_Bus), 0);
    chk("async busy", int'(busy), 0);
    chk("async alu_gnt", int'(alu_gnt), 0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
    model_reset();
    @(posedge clk);
    #1;

    // Random traffic obeying the handshake: an ungranted request is held.
    ap = 0; mp = 0;
    for (int i = 0; i < 400; i++) begin
      if (!ap && ($urandom_range(0, 2) != 0)) begin
        ap = 1; alu_reg = 4'($urandom); alu_data = 16'($urandom);
      end
      if (!mp && ($urandom_range(0, 2) != 0)) begin
        mp = 1; mem_reg = 4'($urandom); mem_data = 16'($urandom);
      end
      alu_req = ap; mem_req = mp;
      reserve_en = ($urandom_range(0, 3) == 0);
      reserve_reg = 4'($urandom);
      cyc(ag, mg);
      chk("rnd alu_gnt", int'(ag), (m_win == 0) ? 1 : 0);
      chk("rnd mem_gnt", int'(mg), (m_win == 1) ? 1 : 0);
      chk("rnd RegWrite", int'(RegWrite), int'(m_we));
      chk("rnd Write_Reg", int'(Write_Reg), m_wreg);
      chk("rnd Write_Bus", int'(Write_Bus), m_wdata);
      chk("rnd busy", int'(busy), model_busy_word());
      if (ag) ap = 0;
      if (mg) mp = 0;
    end
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and destination scoreboard for the 16 x 16-bit register file. Two requesters share the register file's single write port: the ALU write-back path and the memory-load write-back path. Contention is resolved round-robin, and the winner is driven onto the registered RegWrite / Write_Reg / Write_Bus port one cycle after its grant. A 16-bit busy mask tracks destinations reserved by issue and not yet written, so the issue/hazard logic can stall on RAW dependences.

## Interface
- DATA_W, 16, write data width
- ADDR_W, 4, register address width; the register count is 2**ADDR_W
- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  asynchronous, active-low reset
- alu_req  in  1  ALU has a result to write back
- alu_reg  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_gnt  out  1  combinational grant to the ALU, valid in the same cycle as alu_req
- mem_req  in  1  load unit has data to write back
- mem_reg  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- mem_gnt  out  1  combinational grant to the load unit
- reserve_en  in  1  issue stage reserves a destination this cycle
- reserve_reg  in  ADDR_W  register being reserved
- busy  out  2**ADDR_W  registered scoreboard; bit r=1 means register r has a write outstanding
- RegWrite  out  1  registered write enable to the register file
- Write_Reg  out  ADDR_W  registered write address
- Write_Bus  out  DATA_W  registered write data

## Operation
- Grant logic is combinational from the *_req inputs and the last-winner pointer `last` (1 bit: 0 = ALU, 1 = MEM).
  - Only one request: that requester is granted.
  - Both requests: the requester that is not `last` is granted.
  - At most one grant is ever asserted per cycle.
- Handshake rules:
  - A requester holds req, reg and data stable until it sees gnt high; the transfer occurs on that cycle's rising edge.
  - A requester may drop req before it is granted, with no side effects.
  - A requester may issue back-to-back requests; a new transfer every cycle is legal.
- On a granted edge:
  - RegWrite <= 1; Write_Reg and Write_Bus <= the winner's reg and data.
  - `last` <= the winner.
  - busy[winner reg] <= 0.
- On an edge with no grant:
  - RegWrite <= 0.
  - Write_Reg and Write_Bus hold their previous values.
  - `last` is unchanged.
- Scoreboard:
  - On an edge with reserve_en, busy[reserve_reg] <= 1.
  - Set and clear of the same bit on the same edge: set wins, because a new reservation supersedes the completing write.
  - Reserving a register that is already busy leaves it at 1; no count is kept, so issue must not do this.
  - A write-back to a register whose busy bit is 0 is legal. It writes normally and busy stays 0.
- There is no FSM beyond the `last` pointer, the output register and the busy mask. Both requesters are served within 2 cycles under continuous contention, so there is no starvation.
- Both requesters targeting the same register in one cycle: only the winner writes. The loser is written on a later cycle, so the last write wins in grant order.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert handled upstream):
  - RegWrite=0, Write_Reg=0, Write_Bus=0, busy=0, last=1 (the ALU wins the first tie).
  - alu_gnt and mem_gnt follow their combinational equations and are forced to 0 while rst_n=0.
- Latency:
  - Grant in cycle N; RegWrite/Write_Reg/Write_Bus are valid throughout cycle N+1.
  - The register file captures the data at the end of N+1.
  - busy clears at the end of N, so it reads 0 in N+1. Any bypass must cover the N+1 window.
- Throughput: 1 write per cycle total, sustained.
- Reset mid-operation: a pending output write (RegWrite=1) is dropped immediately, all reservations are cleared, and requesters must re-request after reset.

## Test plan
- Reset, then alu_req=1, alu_reg=3, alu_data=16'hBEEF for one cycle -> alu_gnt=1 in that cycle, mem_gnt=0; next cycle RegWrite=1, Write_Reg=3, Write_Bus=16'hBEEF; the following cycle RegWrite=0.
- Both req held 4 cycles (ALU reg 1 / 16'h1111, MEM reg 2 / 16'h2222) after reset -> grants alternate ALU, MEM, ALU, MEM; Write_Reg sequence 1, 2, 1, 2 with no idle cycle.
- reserve_en with reserve_reg=5, then mem write to reg 5 granted two cycles later -> busy[5]=1 from the edge after reservation until the grant edge, then 0; all other busy bits stay 0.
- Same edge: reserve_reg=7 and ALU write-back to reg 7 granted -> busy[7]=1 afterwards; RegWrite=1, Write_Reg=7 on the next cycle.
- Both requesters target reg 9 (ALU 16'hAAAA, MEM 16'h5555) with last=0 -> MEM written first, then ALU; the final value seen on Write_Bus for reg 9 is 16'hAAAA.
- rst_n pulsed low while RegWrite=1 and busy=16'h00F0 -> RegWrite, Write_Reg, Write_Bus and busy read 0 immediately, without waiting for a clock edge.
